drm_metering_gate: RTL and testbench



---
 rtl/drm_metering_gate.sv | 133 +++++++++++++
 tb/tb_drm_metering_gate.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/drm_metering_gate.sv
// DRM metering gate: qualifies the activator licence bit into ip_enable and turns
// weighted job completions into rate-limited metering_event pulses. Optional stats: DRM_METER_STATS_EN.
module drm_metering_gate #(
  parameter int unsigned ACT_BIT       = 0,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned EVT_CNT_W     = 16,
  parameter int unsigned EVT_GAP       = 2
) (
  input  logic                 ip_core_aclk,
  input  logic                 ip_core_arst,
  input  logic [127:0]         activation_code,
  input  logic                 job_done,
  input  logic [7:0]           job_units,
  output logic                 ip_enable,
  output logic                 metering_event,
  output logic [EVT_CNT_W-1:0] pending_count,
  output logic                 overflow
`ifdef DRM_METER_STATS_EN
  ,
  output logic [31:0]          events_total,
  output logic [15:0]          jobs_rejected
`endif
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned GAP_W  = (EVT_GAP > 0) ? $clog2(EVT_GAP + 1) : 1;
  // Wide enough that a full counter plus a 255-unit job never wraps before the clamp test.
  localparam int unsigned SUM_W  = ((EVT_CNT_W > 8) ? EVT_CNT_W : 8) + 1;

  typedef enum logic [1:0] {LOCKED, QUALIFY, ACTIVE} lic_state_t;

  lic_state_t          state, state_next;
  logic [STAB_W-1:0]   stable_cnt, stable_next;
  logic                enable_next;
  logic                lic;
  logic                unused_code;

  logic                accept, emit, sat;
  logic [SUM_W-1:0]    sum, pend_max;
  logic [GAP_W-1:0]    gap_cnt, gap_next;
  logic [EVT_CNT_W-1:0] pending_next;

  assign lic         = activation_code[ACT_BIT];
  assign unused_code = ^activation_code;

  always_ff @(posedge ip_core_aclk) begin
    if (ip_core_arst) begin
      state      <= LOCKED;
      stable_cnt <= '0;
      ip_enable  <= 1'b0;
    end else begin
      state      <= state_next;
      stable_cnt <= stable_next;
      ip_enable  <= enable_next;
    end
  end

  always_comb begin
    state_next  = state;
    stable_next = stable_cnt;
    case (state)
      LOCKED: begin
        if (lic) begin
          stable_next = STAB_W'(1);
          state_next  = (STABLE_CYCLES <= 1) ? ACTIVE : QUALIFY;
        end
      end
      QUALIFY: begin
        if (!lic) begin
          state_next  = LOCKED;
          stable_next = '0;
        end else begin
          stable_next = stable_cnt + STAB_W'(1);
          if (stable_next >= STAB_W'(STABLE_CYCLES)) state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!lic) begin
          state_next  = LOCKED;
          stable_next = '0;
        end
      end
      default: begin
        state_next  = LOCKED;
        stable_next = '0;
      end
    endcase
  end

  always_comb begin
    enable_next = (state_next == ACTIVE);
  end

  always_comb begin
    accept   = job_done & ip_enable;
    emit     = (pending_count != '0) && (gap_cnt == '0);
    pend_max = {{(SUM_W - EVT_CNT_W){1'b0}}, {EVT_CNT_W{1'b1}}};
    sum      = SUM_W'(pending_count) + (accept ? SUM_W'(job_units) : '0) - SUM_W'(emit);
    sat      = (sum > pend_max);
    pending_next = sat ? '1 : sum[EVT_CNT_W-1:0];
    if (emit)                 gap_next = GAP_W'(EVT_GAP);
    else if (gap_cnt != '0)   gap_next = gap_cnt - GAP_W'(1);
    else                      gap_next = gap_cnt;
  end

  always_ff @(posedge ip_core_aclk) begin
    if (ip_core_arst) begin
      pending_count  <= '0;
      metering_event <= 1'b0;
      gap_cnt        <= '0;
      overflow       <= 1'b0;
    end else begin
      pending_count  <= pending_next;
      metering_event <= emit;
      gap_cnt        <= gap_next;
      overflow       <= overflow | sat;
    end
  end

`ifdef DRM_METER_STATS_EN
  always_ff @(posedge ip_core_aclk) begin
    if (ip_core_arst) begin
      events_total  <= '0;
      jobs_rejected <= '0;
    end else begin
      if (emit) events_total <= events_total + 32'd1;
      if (job_done && !ip_enable && (jobs_rejected != '1))
        jobs_rejected <= jobs_rejected + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_drm_metering_gate.sv
// Self-checking bench for drm_metering_gate: two configurations driven in parallel,
// table-driven licence vectors, hand sequences for corner cases, random run against a reference model.
module tb_drm_metering_gate;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] code;
  logic         jd;
  logic [7:0]   units;

  logic        en_a, evt_a, ovf_a;
  logic [15:0] pend_a;
  logic        en_b, evt_b, ovf_b;
  logic [3:0]  pend_b;
`ifdef DRM_METER_STATS_EN
  logic [31:0] tot_a, tot_b;
  logic [15:0] rej_a, rej_b;
`endif

  drm_metering_gate #(.ACT_BIT(0), .STABLE_CYCLES(S), .EVT_CNT_W(16), .EVT_GAP(2)) dut_a (
    .ip_core_aclk(clk), .ip_core_arst(rst), .activation_code(code),
    .job_done(jd), .job_units(units), .ip_enable(en_a), .metering_event(evt_a),
    .pending_count(pend_a), .overflow(ovf_a)
`ifdef DRM_METER_STATS_EN
    , .events_total(tot_a), .jobs_rejected(rej_a)
`endif
  );

  drm_metering_gate #(.ACT_BIT(77), .STABLE_CYCLES(S), .EVT_CNT_W(4), .EVT_GAP(0)) dut_b (
    .ip_core_aclk(clk), .ip_core_arst(rst), .activation_code(code),
    .job_done(jd), .job_units(units), .ip_enable(en_b), .metering_event(evt_b),
    .pending_count(pend_b), .overflow(ovf_b)
`ifdef DRM_METER_STATS_EN
    , .events_total(tot_b), .jobs_rejected(rej_b)
`endif
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: licence = run length of sampled 1s, pending = plain integer with clamp.
  int     act_bit[2] = '{0, 77};
  int     gap[2]     = '{2, 0};
  longint pmax[2]    = '{65535, 15};
  int     run[2];
  bit     m_en[2], m_ovf[2], m_evt[2];
  longint m_pend[2], m_tot[2];
  int     since[2], m_rej[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; m_en[i] = 0; m_ovf[i] = 0; m_evt[i] = 0;
      m_pend[i] = 0; m_tot[i] = 0; since[i] = gap[i]; m_rej[i] = 0;
    end
  endfunction

  function automatic void model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      bit     lic;
      bit     emit;
      longint p;
      lic  = code[act_bit[i]];
      emit = (m_pend[i] > 0) && (since[i] >= gap[i]);
      p    = m_pend[i] + ((jd && m_en[i]) ? longint'(units) : 0) - (emit ? 1 : 0);
      if (p > pmax[i]) begin
        p = pmax[i];
        m_ovf[i] = 1;
      end
      if (jd && !m_en[i] && m_rej[i] < 65535) m_rej[i]++;
      if (emit) m_tot[i] = (m_tot[i] + 1) % 64'h1_0000_0000;
      since[i]  = emit ? 0 : ((since[i] < 1000) ? since[i] + 1 : since[i]);
      run[i]    = lic ? ((run[i] < 1000) ? run[i] + 1 : run[i]) : 0;
      m_en[i]   = (run[i] >= S);
      m_pend[i] = p;
      m_evt[i]  = emit;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_en_a",   en_a,   m_en[0]);
    chk("model_evt_a",  evt_a,  m_evt[0]);
    chk("model_pend_a", pend_a, m_pend[0]);
    chk("model_ovf_a",  ovf_a,  m_ovf[0]);
    chk("model_en_b",   en_b,   m_en[1]);
    chk("model_evt_b",  evt_b,  m_evt[1]);
    chk("model_pend_b", pend_b, m_pend[1]);
    chk("model_ovf_b",  ovf_b,  m_ovf[1]);
`ifdef DRM_METER_STATS_EN
    chk("model_tot_a", tot_a, m_tot[0]);
    chk("model_rej_a", rej_a, m_rej[0]);
    chk("model_tot_b", tot_b, m_tot[1]);
    chk("model_rej_b", rej_b, m_rej[1]);
`endif
  endtask

  task automatic set_lic(input bit a, input bit b);
    code[0]  = a;
    code[77] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1; jd = 1'b0; units = '0; code = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic activate();
    set_lic(1'b1, 1'b1);
    repeat (S) tick();
  endtask

  typedef struct {
    bit lic;
    bit exp_en;
  } vec_t;
  vec_t tbl[19];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int pulses;
    int last;

    rst = 1'b1; code = '0; jd = 1'b0; units = '0;

    // Qualify from cycle 0, drop at cycle 10, then a 3-cycle glitch and re-qualify.
    for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, (i >= 3)};
    tbl[10] = '{1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0}; tbl[12] = '{1'b1, 1'b0}; tbl[13] = '{1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0}; tbl[16] = '{1'b1, 1'b0}; tbl[17] = '{1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b1};

    do_reset();
    chk("reset_en_a", en_a, 0);
    chk("reset_evt_a", evt_a, 0);
    chk("reset_pend_a", pend_a, 0);
    chk("reset_ovf_a", ovf_a, 0);
    chk("reset_pend_b", pend_b, 0);

    for (int i = 0; i < 19; i++) begin
      set_lic(tbl[i].lic, tbl[i].lic);
      tick();
      chk($sformatf("tbl_en_a[%0d]", i), en_a, tbl[i].exp_en);
      chk($sformatf("tbl_en_b[%0d]", i), en_b, tbl[i].exp_en);
    end

    // Three units metered with a spacing of EVT_GAP+1 cycles.
    do_reset();
    activate();
    jd = 1'b1; units = 8'd3;
    tick();
    jd = 1'b0;
    chk("meter_pend_initial", pend_a, 3);
    pulses = 0; last = -1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (evt_a) begin
        if (pulses > 0) chk("meter_spacing", i - last, 3);
        pulses++;
        last = i;
      end
    end
    chk("meter_pulses", pulses, 3);
    chk("meter_pend_final", pend_a, 0);
    chk("meter_ovf", ovf_a, 0);

    // Add and emit on the same edge.
    do_reset();
    activate();
    jd = 1'b1; units = 8'd5;
    tick();
    jd = 1'b0;
    chk("simul_pend5", pend_a, 5);
    tick();
    chk("simul_evt1", evt_a, 1);
    chk("simul_pend4", pend_a, 4);
    tick();
    tick();
    jd = 1'b1; units = 8'd2;
    tick();
    jd = 1'b0;
    chk("simul_evt2", evt_a, 1);
    chk("simul_pend5b", pend_a, 5);
    pulses = 2;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (evt_a) pulses++;
    end
    chk("simul_pulses", pulses, 7);
    chk("simul_pend_final", pend_a, 0);

    // Saturation on the 4-bit, gap-0 instance.
    do_reset();
    activate();
    jd = 1'b1; units = 8'd10;
    tick();
    chk("sat_pend10", pend_b, 10);
    tick();
    jd = 1'b0;
    chk("sat_pend15", pend_b, 15);
    chk("sat_ovf", ovf_b, 1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (evt_b) pulses++;
    end
    chk("sat_pulses", pulses, 15);
    chk("sat_ovf_sticky", ovf_b, 1);
    chk("sat_pend_drained", pend_b, 0);
    do_reset();
    chk("sat_reset_ovf", ovf_b, 0);
    chk("sat_reset_pend", pend_b, 0);

`ifdef DRM_METER_STATS_EN
    do_reset();
    set_lic(1'b0, 1'b0);
    jd = 1'b1; units = 8'd5;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (evt_a) pulses++;
    end
    jd = 1'b0;
    chk("locked_pulses", pulses, 0);
    chk("locked_pend", pend_a, 0);
    chk("locked_rejected", rej_a, 3);
    activate();
    jd = 1'b1; units = 8'd4;
    tick();
    jd = 1'b0;
    repeat (20) tick();
    chk("stats_events_total", tot_a, 4);
`endif

    // Random stimulus against the model, with occasional resets and large jobs.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      code     = {$urandom, $urandom, $urandom, $urandom};
      code[0]  = ($urandom_range(0, 19) != 0);
      code[77] = ($urandom_range(0, 19) != 0);
      jd       = ($urandom_range(0, 2) == 0);
      units    = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(100, 255))
                                              : 8'($urandom_range(0, 6));
      tick();
    end
    rst = 1'b0; jd = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
